// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl
//   Frame sequencer for the Sobel edge datapath. It reads a grayscale frame
//   in raster order, builds 3x3 windows from two line buffers, presents them
//   to sobel_calc and writes the returned edge pixels to a result memory.
//
//   Parameters: IMG_W, IMG_H (>= 3), ADDR_W (2^ADDR_W >= IMG_W*IMG_H).
//   Ports:
//     clk, rst (sync, active-high)
//     start_i            frame start pulse, sampled only in IDLE
//     busy_o, done_o     frame in progress / one-cycle completion pulse
//     rd_en_o, rd_addr_o, rd_data_i    frame memory (1-cycle read latency)
//     d0_o..d8_o, win_valid_o          3x3 window, row-major, d0 top-left
//     edge_i, edge_valid_i             edge result from sobel_calc
//     wr_en_o, wr_addr_o, wr_data_o    result memory write port
//
//   Optional macro SOBEL_FRAME_CTRL_BORDER_EN: full-size result layout with
//   interior results at their centre address and a BORDER pass that zeroes
//   every border pixel. Undefined: compact (IMG_W-2)x(IMG_H-2) layout.
module sobel_frame_ctrl #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [7:0]        rd_data_i,
    output logic [7:0]        d0_o,
    output logic [7:0]        d1_o,
    output logic [7:0]        d2_o,
    output logic [7:0]        d3_o,
    output logic [7:0]        d4_o,
    output logic [7:0]        d5_o,
    output logic [7:0]        d6_o,
    output logic [7:0]        d7_o,
    output logic [7:0]        d8_o,
    output logic              win_valid_o,
    input  logic [7:0]        edge_i,
    input  logic              edge_valid_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0]     C_LAST    = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     R_LAST    = RW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] OUT_TOTAL = ADDR_W'((IMG_W - 2) * (IMG_H - 2));
`ifdef SOBEL_FRAME_CTRL_BORDER_EN
    localparam logic [ADDR_W-1:0] N_LAST    = ADDR_W'(IMG_W * IMG_H - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
`ifdef SOBEL_FRAME_CTRL_BORDER_EN
        BORDER,
`endif
        DONE
    } state_t;

    state_t state;

    // Coordinates of the address currently on rd_addr_o
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    // Coordinates of the pixel currently on rd_data_i
    logic          pix_valid;
    logic [RW-1:0] pix_row;
    logic [CW-1:0] pix_col;

    logic [7:0] lb0 [IMG_W];   // row r-1
    logic [7:0] lb1 [IMG_W];   // row r-2

    logic [ADDR_W-1:0] out_cnt;

`ifdef SOBEL_FRAME_CTRL_BORDER_EN
    // Interior write pointer walks centres (1,1)..(H-2,W-2) in full layout
    logic [CW-1:0]     ocol;
    logic [ADDR_W-1:0] wr_ptr;
    // Border walker: visits only border addresses, ascending
    logic [RW-1:0]     brow;
    logic [CW-1:0]     bcol;
    logic [ADDR_W-1:0] baddr;
`endif

    // Line buffers carry no reset so they can map onto RAM
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb0[pix_col] <= rd_data_i;
            lb1[pix_col] <= lb0[pix_col];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            rd_en_o     <= 1'b0;
            rd_addr_o   <= '0;
            row         <= '0;
            col         <= '0;
            pix_valid   <= 1'b0;
            pix_row     <= '0;
            pix_col     <= '0;
            {d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o} <= '0;
            win_valid_o <= 1'b0;
            wr_en_o     <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            out_cnt     <= '0;
`ifdef SOBEL_FRAME_CTRL_BORDER_EN
            ocol        <= '0;
            wr_ptr      <= '0;
            brow        <= '0;
            bcol        <= '0;
            baddr       <= '0;
`endif
        end else begin
            done_o    <= 1'b0;
            wr_en_o   <= 1'b0;
            pix_valid <= rd_en_o;
            pix_row   <= row;
            pix_col   <= col;

            // Window shift: columns move left, new column enters on the right
            if (state == IDLE) begin
                {d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o} <= '0;
                win_valid_o <= 1'b0;
            end else begin
                win_valid_o <= pix_valid && (pix_row >= RW'(2)) && (pix_col >= CW'(2));
                if (pix_valid) begin
                    d0_o <= d1_o;  d1_o <= d2_o;  d2_o <= lb1[pix_col];
                    d3_o <= d4_o;  d4_o <= d5_o;  d5_o <= lb0[pix_col];
                    d6_o <= d7_o;  d7_o <= d8_o;  d8_o <= rd_data_i;
                end
            end

            // Result collection: counts results, independent of datapath latency
            if ((state == READ || state == DRAIN) && edge_valid_i) begin
                wr_en_o   <= 1'b1;
                wr_data_o <= edge_i;
                out_cnt   <= out_cnt + 1'b1;
`ifdef SOBEL_FRAME_CTRL_BORDER_EN
                wr_addr_o <= wr_ptr;
                if (ocol == CW'(IMG_W - 3)) begin
                    ocol   <= '0;
                    wr_ptr <= wr_ptr + ADDR_W'(3);
                end else begin
                    ocol   <= ocol + 1'b1;
                    wr_ptr <= wr_ptr + 1'b1;
                end
`else
                wr_addr_o <= out_cnt;
`endif
            end

            case (state)
                IDLE: begin
                    busy_o  <= 1'b0;
                    row     <= '0;
                    col     <= '0;
                    out_cnt <= '0;
`ifdef SOBEL_FRAME_CTRL_BORDER_EN
                    ocol    <= '0;
                    wr_ptr  <= ADDR_W'(IMG_W + 1);
`endif
                    if (start_i) begin
                        state     <= READ;
                        busy_o    <= 1'b1;
                        rd_en_o   <= 1'b1;
                        rd_addr_o <= '0;
                    end
                end
                READ: begin
                    if (row == R_LAST && col == C_LAST) begin
                        rd_en_o <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        rd_addr_o <= rd_addr_o + 1'b1;
                        if (col == C_LAST) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_cnt == OUT_TOTAL) begin
`ifdef SOBEL_FRAME_CTRL_BORDER_EN
                        state <= BORDER;
                        brow  <= '0;
                        bcol  <= '0;
                        baddr <= '0;
`else
                        state  <= DONE;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
`endif
                    end
                end
`ifdef SOBEL_FRAME_CTRL_BORDER_EN
                BORDER: begin
                    wr_en_o   <= 1'b1;
                    wr_addr_o <= baddr;
                    wr_data_o <= '0;
                    if (baddr == N_LAST) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                    end else if (bcol == C_LAST) begin
                        bcol  <= '0;
                        brow  <= brow + 1'b1;
                        baddr <= baddr + 1'b1;
                    end else if (brow == '0 || brow == R_LAST) begin
                        bcol  <= bcol + 1'b1;
                        baddr <= baddr + 1'b1;
                    end else begin
                        // Interior row: jump from left edge straight to right edge
                        bcol  <= C_LAST;
                        baddr <= baddr + ADDR_W'(IMG_W - 1);
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
